muldiv_unit: RTL

- Parametrised, iterative multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle HI/LO logic inside the ALU:
  - operand width is a parameter;
  - signed and unsigned modes;
  - MTHI/MTLO writes;
  - start/busy/done handshake;
  - flush.
- Sits beside the ALU in the execute stage. The pipeline stalls on MFHI/MFLO while busy is high.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply or restoring divide at one bit per cycle, then a one-cycle sign fix-up.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] acc_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign busy = (state != ST_IDLE);

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (-a) : a;
    b_mag     = b_neg ? (-b) : b;
  end

  // The accumulator holds {partial product} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_addend = acc[0] ? opnd : '0;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial  = {1'b0, div_shift} - {2'b00, opnd};
    acc_next   = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH+1]) begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  // A zero divisor leaves the dividend magnitude as remainder, so re-signing it restores a exactly.
  always_comb begin
    prod_fix = neg_lo ? (-acc) : acc;
    quot     = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_hi ? (-rem) : rem;
      res_lo = div_zero ? '1 : (neg_lo ? (-quot) : quot);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op[1];
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= a_neg;
                div_zero <= (b == '0);
                acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                opnd     <= op[1] ? b_mag : a_mag;
                cnt      <= '0;
                state    <= ST_CALC;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
